mux_8_1_rr: RTL and testbench
=============================

Name: mux_8_1_rr

Overview:
- Round-robin 8:1 collector: eight source channels compete for one output stream. It is the gathering end of the 1:8 demux path.
- Each source has a valid/ready handshake. The granted channel's data is registered onto a single valid/ready output.
- The output carries the 3-bit source index, so a downstream demux_1_8_M can route the data back by S.
- Optional packet lock keeps the grant on one channel until that channel's last beat.

Parameters:
- W, 8, data width per channel.
- LOCK, 1, 1 = hold grant until in_last beat; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  8  per-channel data valid; bit i = channel i.
- in_data  in  8*W  channel i data at [i*W +: W].
- in_last  in  8  per-channel last-beat-of-packet flag; ignored when LOCK=0.
- in_ready  out  8  one-hot grant/accept; at most one bit high.
- out_valid  out  1  output register holds data.
- out_data  out  W  registered data.
- out_sel  out  3  registered source channel index (maps to demux S).
- out_last  out  1  registered copy of the accepted in_last bit.
- out_ready  in  1  downstream accepts when high with out_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, state=IDLE.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - Reset mid-packet discards the held beat and any lock.
- Output register:
  - can_load = !out_valid | out_ready.
  - A downstream transfer occurs when out_valid & out_ready. The register clears unless it is reloaded in the same cycle.
  - Sustained throughput is 1 beat/cycle. Latency is 1 cycle from source transfer to out_valid.
- Arbitration in IDLE:
  - grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ... ptr+7 with mod-8 wrap.
  - in_ready[grant]=can_load; all other in_ready bits = 0.
  - If no in_valid is set, in_ready=0.
- Source transfer: in_valid[g] & in_ready[g]. On transfer:
  - out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - ptr <= g+1 mod 8, so 7 wraps to 0.
- FSM (LOCK=1), states IDLE and LOCKED with lock register lch[2:0]:
  - IDLE -> LOCKED on a transfer with in_last[g]=0; lch <= g.
  - IDLE stays IDLE on a transfer with in_last=1 (single-beat packet).
  - In LOCKED, only channel lch is eligible. in_ready = onehot(lch) & can_load. Other valids wait even if lch is idle.
  - LOCKED -> IDLE on a lch transfer with in_last=1. ptr <= lch+1.
- LOCK=0: the FSM stays in IDLE and in_last is passed through to out_last only.
- in_ready depends combinationally on in_valid and out_ready; no combinational path from in_data.
- Sources may not drop in_valid before their transfer. This is a protocol rule; the block does not check it.
- Simultaneous drain and load: the new beat replaces the old one with no bubble, and out_valid stays 1.
- All-valid case: grants rotate ptr order 0,1,...,7,0 with no starvation. Worst-case wait is 7 beats in IDLE, plus lock duration in LOCKED.

Decomposition:
- Shared package (mux_demux_pkg):
  - CH_N=8, SEL_W=3.
  - State encoding ST_IDLE=1'b0, ST_LOCKED=1'b1.
  - A function for the circular priority pick.
- One natural sub-module: rr_arbiter_8 (inputs req[7:0], ptr[2:0], en; outputs onehot grant[7:0], idx[2:0], any). It is pure combinational.
- The top level holds ptr, the FSM, and the output register.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with in_valid=8'hFF. Required: in_ready=0, out_valid=0, out_sel=0, out_data=0 throughout. After release, the first grant goes to channel 0.
- Round-robin fairness: LOCK=0, in_valid=8'hFF, in_last=8'hFF, in_data[i]=8'h10+i, out_ready=1. Required: out_sel sequence 0,1,...,7,0 on consecutive cycles, out_data=8'h10..8'h17, one beat/cycle.
- Wrap and skip: ptr=6 after a grant to 5; in_valid=8'b0000_0101. Required: grant to channel 0, then channel 2, then channel 0 again.
- Backpressure: hold out_ready=0 for 4 cycles after one beat loads. Required: out_valid=1 and out_data stable, in_ready=0. On out_ready=1, the next beat loads in the same cycle with no bubble.
- Packet lock: LOCK=1. Channel 3 sends 3 beats (in_last=0,0,1) while channel 4 is valid. Required: out_sel=3,3,3, then 4. in_ready[4]=0 until channel 3's last beat.
- Mid-packet reset: in LOCKED on channel 5 after 1 beat, assert rst_n=0 for 1 cycle. Required: out_valid=0, FSM back to IDLE, next grant from ptr=0.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// rtl/mux_demux_pkg.sv - shared constants, FSM encoding and round-robin pick helpers
package mux_demux_pkg;

  localparam int CH_N  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // First requesting channel scanning ptr, ptr+1, ... with mod-8 wrap; returns ptr if none request.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [CH_N-1:0]  req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < CH_N; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [CH_N-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return CH_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - combinational 8-way round-robin arbiter
module rr_arbiter_8
  import mux_demux_pkg::*;
(
  input  logic [CH_N-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [CH_N-1:0]  grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  always_comb begin
    any   = |req;
    idx   = rr_pick(req, ptr);
    grant = (en && any) ? onehot8(idx) : '0;
  end

endmodule

// File: rtl/mux_8_1_rr.sv
// rtl/mux_8_1_rr.sv - round-robin 8:1 collector with optional packet lock
module mux_8_1_rr
  import mux_demux_pkg::*;
#(
  parameter int W    = 8,
  parameter bit LOCK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_N-1:0]     in_valid,
  input  logic [CH_N*W-1:0]   in_data,
  input  logic [CH_N-1:0]     in_last,
  output logic [CH_N-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_last,
  input  logic                out_ready
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  lch_q, lch_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_last_q, out_last_d;

  logic              can_load;
  logic              arb_en;
  logic              arb_any;
  logic              xfer;
  logic [CH_N-1:0]   req;
  logic [CH_N-1:0]   grant;
  logic [SEL_W-1:0]  g;

  // While locked only the locked channel may compete, even if it is idle.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    arb_en   = can_load && rst_n;
    req      = (state_q == ST_LOCKED) ? (in_valid & onehot8(lch_q)) : in_valid;
  end

  rr_arbiter_8 u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (g),
    .any   (arb_any)
  );

  assign xfer     = arb_any && arb_en;
  assign in_ready = grant;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lch_d       = lch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A load in the same cycle as a drain overrides the clear, giving no bubble.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(g)*W +: W];
      out_sel_d   = g;
      out_last_d  = in_last[g];
      ptr_d       = g + SEL_W'(1);
      if (LOCK) begin
        if (state_q == ST_IDLE && !in_last[g]) begin
          state_d = ST_LOCKED;
          lch_d   = g;
        end else if (state_q == ST_LOCKED && in_last[g]) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lch_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lch_q       <= lch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_8_1_rr.sv
// tb/tb_mux_8_1_rr.sv - directed self-checking bench for mux_8_1_rr (LOCK=0 and LOCK=1)
module tb_mux_8_1_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_last;
  logic        out_ready;

  logic [7:0]  r0_in_ready, r1_in_ready;
  logic        r0_out_valid, r1_out_valid;
  logic [7:0]  r0_out_data, r1_out_data;
  logic [2:0]  r0_out_sel, r1_out_sel;
  logic        r0_out_last, r1_out_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_8_1_rr #(.W(8), .LOCK(1'b0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (r0_in_ready),
    .out_valid (r0_out_valid),
    .out_data  (r0_out_data),
    .out_sel   (r0_out_sel),
    .out_last  (r0_out_last),
    .out_ready (out_ready)
  );

  mux_8_1_rr #(.W(8), .LOCK(1'b1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (r1_in_ready),
    .out_valid (r1_out_valid),
    .out_data  (r1_out_data),
    .out_sel   (r1_out_sel),
    .out_last  (r1_out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    in_last   = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);

    settle();
    chk("rst_in_ready_comb", 32'(r0_in_ready), 32'h00);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_in_ready0", 32'(r0_in_ready), 32'h00);
      chk("rst_in_ready1", 32'(r1_in_ready), 32'h00);
      chk("rst_out_valid", 32'(r0_out_valid), 32'h0);
      chk("rst_out_sel", 32'(r0_out_sel), 32'h0);
      chk("rst_out_data", 32'(r0_out_data), 32'h0);
    end

    rst_n = 1'b1;
    settle();
    chk("first_grant0", 32'(r0_in_ready), 32'h01);
    chk("first_grant1", 32'(r1_in_ready), 32'h01);

    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr_valid", 32'(r0_out_valid), 32'h1);
      chk("rr_sel", 32'(r0_out_sel), 32'(k % 8));
      chk("rr_data", 32'(r0_out_data), 32'h10 + 32'(k % 8));
    end

    in_valid = 8'h20;
    settle();
    chk("single_ch5_ready", 32'(r0_in_ready), 32'h20);
    tick();
    chk("grant5_sel", 32'(r0_out_sel), 32'h5);
    in_valid = 8'h05;
    settle();
    chk("wrap_ready", 32'(r0_in_ready), 32'h01);
    tick();
    chk("wrap_sel0", 32'(r0_out_sel), 32'h0);
    settle();
    chk("skip_ready", 32'(r0_in_ready), 32'h04);
    tick();
    chk("skip_sel2", 32'(r0_out_sel), 32'h2);
    tick();
    chk("wrap_again_sel0", 32'(r0_out_sel), 32'h0);
    chk("wrap_again_data", 32'(r0_out_data), 32'h10);

    out_ready = 1'b0;
    in_valid  = 8'h04;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("bp_in_ready", 32'(r0_in_ready), 32'h00);
      tick();
      chk("bp_valid", 32'(r0_out_valid), 32'h1);
      chk("bp_data", 32'(r0_out_data), 32'h10);
      chk("bp_sel", 32'(r0_out_sel), 32'h0);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(r0_in_ready), 32'h04);
    tick();
    chk("bp_nobubble_valid", 32'(r0_out_valid), 32'h1);
    chk("bp_nobubble_sel", 32'(r0_out_sel), 32'h2);
    chk("bp_nobubble_data", 32'(r0_out_data), 32'h12);
    in_valid = 8'h00;
    tick();
    chk("drain_valid", 32'(r0_out_valid), 32'h0);

    in_valid = 8'h18;
    in_last  = 8'hF7;
    settle();
    chk("lock_b1_ready", 32'(r1_in_ready), 32'h08);
    tick();
    chk("lock_b1_sel", 32'(r1_out_sel), 32'h3);
    chk("lock_b1_last", 32'(r1_out_last), 32'h0);
    settle();
    chk("lock_b2_ready", 32'(r1_in_ready), 32'h08);
    tick();
    chk("lock_b2_sel", 32'(r1_out_sel), 32'h3);
    chk("nolock_sel4", 32'(r0_out_sel), 32'h4);
    in_last = 8'hFF;
    settle();
    chk("lock_b3_ready", 32'(r1_in_ready), 32'h08);
    tick();
    chk("lock_b3_sel", 32'(r1_out_sel), 32'h3);
    chk("lock_b3_last", 32'(r1_out_last), 32'h1);
    settle();
    chk("unlock_ready", 32'(r1_in_ready), 32'h10);
    tick();
    chk("unlock_sel4", 32'(r1_out_sel), 32'h4);
    chk("unlock_data", 32'(r1_out_data), 32'h14);

    in_valid = 8'h22;
    in_last  = 8'h00;
    settle();
    chk("mid_ready5", 32'(r1_in_ready), 32'h20);
    tick();
    chk("mid_sel5", 32'(r1_out_sel), 32'h5);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_ready", 32'(r1_in_ready), 32'h00);
    tick();
    chk("mid_rst_valid", 32'(r1_out_valid), 32'h0);
    chk("mid_rst_sel", 32'(r1_out_sel), 32'h0);
    chk("mid_rst_data", 32'(r1_out_data), 32'h0);
    rst_n    = 1'b1;
    in_valid = 8'h62;
    in_last  = 8'hFF;
    settle();
    chk("post_rst_ready", 32'(r1_in_ready), 32'h02);
    tick();
    chk("post_rst_sel", 32'(r1_out_sel), 32'h1);
    chk("post_rst_valid", 32'(r1_out_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
